// File: rtl/light_conflict_monitor.sv
// light_conflict_monitor
// Safety monitor between the traffic-light controller and the lamp drivers.
// Every sampled aspect is checked for illegal encoding, cross-group conflict,
// illegal sequencing and short green/yellow dwell. A violation latches a fault,
// keeps the offending aspect off the lamps and flashes all-red until an
// operator clear is accepted while every lane requests red.

module light_conflict_monitor #(
    parameter int MIN_GREEN  = 3,
    parameter int MIN_YELLOW = 2,
    parameter int FLASH_HALF = 4,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] Light_M1,
    input  logic [2:0] Light_M2,
    input  logic [2:0] Light_M3,
    input  logic [2:0] Light_M4,
    input  logic       clear_fault,
    output logic [2:0] Lamp_M1,
    output logic [2:0] Lamp_M2,
    output logic [2:0] Lamp_M3,
    output logic [2:0] Lamp_M4,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_lane
);

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] DARK   = 3'b000;

    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] DWELL_MAX   = '1;
    localparam logic [CNT_W-1:0] MIN_GREEN_C = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_YELLOW_C = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_HALF - 1);

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_ENCODING = 3'd1;
    localparam logic [2:0] CODE_CONFLICT = 3'd2;
    localparam logic [2:0] CODE_SEQUENCE = 3'd3;
    localparam logic [2:0] CODE_SHORT_G  = 3'd4;
    localparam logic [2:0] CODE_SHORT_Y  = 3'd5;

    typedef enum logic [1:0] {
        S_PASS      = 2'd0,
        S_FLASH_ON  = 2'd1,
        S_FLASH_OFF = 2'd2
    } state_t;

    // Registered state
    state_t           r_state;
    logic [2:0]       r_lamp     [4];
    logic [2:0]       r_prev     [4];
    logic [CNT_W-1:0] r_dwell    [4];
    logic [CNT_W-1:0] r_flashCnt;
    logic             r_fault;
    logic [2:0]       r_code;
    logic [1:0]       r_lane;

    // Combinational next values and check results
    logic [2:0]       w_light    [4];
    logic [3:0]       w_nonRed;
    logic [3:0]       w_badEnc;
    logic [3:0]       w_badSeq;
    logic [3:0]       w_shortGreen;
    logic [3:0]       w_shortYellow;
    logic             w_conflict;
    logic             w_allRed;
    logic             w_violation;
    logic [2:0]       w_vCode;
    logic [1:0]       w_vLane;

    state_t           w_nextState;
    logic [2:0]       w_nextLamp  [4];
    logic [2:0]       w_nextPrev  [4];
    logic [CNT_W-1:0] w_nextDwell [4];
    logic [CNT_W-1:0] w_nextFlashCnt;
    logic             w_nextFault;
    logic [2:0]       w_nextCode;
    logic [1:0]       w_nextLane;

    assign w_light[0] = Light_M1;
    assign w_light[1] = Light_M2;
    assign w_light[2] = Light_M3;
    assign w_light[3] = Light_M4;

    assign Lamp_M1    = r_lamp[0];
    assign Lamp_M2    = r_lamp[1];
    assign Lamp_M3    = r_lamp[2];
    assign Lamp_M4    = r_lamp[3];
    assign fault      = r_fault;
    assign fault_code = r_code;
    assign fault_lane = r_lane;

    // Index of the lowest set bit; lower lanes win ties within a fault class
    function automatic logic [1:0] lowestLane(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Classify each lane's sampled aspect against its history and pick the winning violation
    always_comb begin
        w_nonRed      = '0;
        w_badEnc      = '0;
        w_badSeq      = '0;
        w_shortGreen  = '0;
        w_shortYellow = '0;
        for (int i = 0; i < 4; i++) begin
            w_nonRed[i]      = (w_light[i] != RED);
            w_badEnc[i]      = !((w_light[i] == RED) || (w_light[i] == YELLOW) ||
                                 (w_light[i] == GREEN));
            w_badSeq[i]      = ((r_prev[i] == GREEN)  && (w_light[i] == RED))    ||
                               ((r_prev[i] == RED)    && (w_light[i] == YELLOW)) ||
                               ((r_prev[i] == YELLOW) && (w_light[i] == GREEN));
            w_shortGreen[i]  = (r_prev[i] == GREEN)  && (w_light[i] != GREEN) &&
                               (r_dwell[i] < MIN_GREEN_C);
            w_shortYellow[i] = (r_prev[i] == YELLOW) && (w_light[i] != YELLOW) &&
                               (r_dwell[i] < MIN_YELLOW_C);
        end
        w_conflict = (w_nonRed[0] | w_nonRed[1]) & (w_nonRed[2] | w_nonRed[3]);
        w_allRed   = ~|w_nonRed;

        w_vCode = CODE_NONE;
        w_vLane = 2'd0;
        if (|w_badEnc) begin
            w_vCode = CODE_ENCODING;
            w_vLane = lowestLane(w_badEnc);
        end else if (w_conflict) begin
            w_vCode = CODE_CONFLICT;
            w_vLane = lowestLane(w_nonRed);
        end else if (|w_badSeq) begin
            w_vCode = CODE_SEQUENCE;
            w_vLane = lowestLane(w_badSeq);
        end else if (|w_shortGreen) begin
            w_vCode = CODE_SHORT_G;
            w_vLane = lowestLane(w_shortGreen);
        end else if (|w_shortYellow) begin
            w_vCode = CODE_SHORT_Y;
            w_vLane = lowestLane(w_shortYellow);
        end
        w_violation = (w_vCode != CODE_NONE);
    end

    // Next-state, lamp drive, fault latch and per-lane history update
    always_comb begin
        w_nextState    = r_state;
        w_nextFlashCnt = r_flashCnt;
        w_nextFault    = r_fault;
        w_nextCode     = r_code;
        w_nextLane     = r_lane;
        for (int i = 0; i < 4; i++) begin
            w_nextLamp[i]  = r_lamp[i];
            w_nextPrev[i]  = r_prev[i];
            w_nextDwell[i] = r_dwell[i];
        end

        unique case (r_state)
            S_PASS: begin
                if (w_violation) begin
                    w_nextState    = S_FLASH_ON;
                    w_nextFlashCnt = '0;
                    w_nextFault    = 1'b1;
                    w_nextCode     = w_vCode;
                    w_nextLane     = w_vLane;
                    for (int i = 0; i < 4; i++) w_nextLamp[i] = RED;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        w_nextLamp[i] = w_light[i];
                        w_nextPrev[i] = w_light[i];
                        if (w_light[i] != r_prev[i]) begin
                            w_nextDwell[i] = ONE;
                        end else if (r_dwell[i] != DWELL_MAX) begin
                            w_nextDwell[i] = r_dwell[i] + ONE;
                        end
                    end
                end
            end
            S_FLASH_ON, S_FLASH_OFF: begin
                if (clear_fault && w_allRed) begin
                    w_nextState    = S_PASS;
                    w_nextFlashCnt = '0;
                    w_nextFault    = 1'b0;
                    w_nextCode     = CODE_NONE;
                    w_nextLane     = 2'd0;
                    for (int i = 0; i < 4; i++) begin
                        w_nextLamp[i]  = RED;
                        w_nextPrev[i]  = RED;
                        w_nextDwell[i] = ONE;
                    end
                end else if (r_flashCnt == FLASH_LAST) begin
                    w_nextFlashCnt = '0;
                    w_nextState    = (r_state == S_FLASH_ON) ? S_FLASH_OFF : S_FLASH_ON;
                    for (int i = 0; i < 4; i++) begin
                        w_nextLamp[i] = (r_state == S_FLASH_ON) ? DARK : RED;
                    end
                end else begin
                    w_nextFlashCnt = r_flashCnt + ONE;
                    for (int i = 0; i < 4; i++) begin
                        w_nextLamp[i] = (r_state == S_FLASH_ON) ? RED : DARK;
                    end
                end
            end
            default: begin
                w_nextState = S_PASS;
                for (int i = 0; i < 4; i++) w_nextLamp[i] = RED;
            end
        endcase
    end

    // State register with synchronous active-low reset to a safe all-red pass state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_PASS;
            r_flashCnt <= '0;
            r_fault    <= 1'b0;
            r_code     <= CODE_NONE;
            r_lane     <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_lamp[i]  <= RED;
                r_prev[i]  <= RED;
                r_dwell[i] <= ONE;
            end
        end else begin
            r_state    <= w_nextState;
            r_flashCnt <= w_nextFlashCnt;
            r_fault    <= w_nextFault;
            r_code     <= w_nextCode;
            r_lane     <= w_nextLane;
            for (int i = 0; i < 4; i++) begin
                r_lamp[i]  <= w_nextLamp[i];
                r_prev[i]  <= w_nextPrev[i];
                r_dwell[i] <= w_nextDwell[i];
            end
        end
    end

endmodule

// File: doc/light_conflict_monitor.md
Name: light_conflict_monitor

Overview:
Safety monitor at the output end of the traffic-light controller's lane interface: consumes the four Light_M* aspect buses and drives the physical lamp buses Lamp_M*. Checks every sampled aspect for encoding, cross-road conflict, sequence and minimum-dwell violations. On any violation it latches a fault, blocks the offending aspect from ever reaching the lamps, and flashes all-red until an operator clear.

Parameters:
MIN_GREEN, 3, minimum consecutive sampled cycles a lane must hold green before leaving it
MIN_YELLOW, 2, minimum consecutive sampled cycles a lane must hold yellow before leaving it
FLASH_HALF, 4, cycles per half-period of the failsafe red flash
CNT_W, 4, width of per-lane dwell counters and flash counter (saturating)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset
Light_M1  in  3  lane 0 aspect from controller
Light_M2  in  3  lane 1 aspect
Light_M3  in  3  lane 2 aspect
Light_M4  in  3  lane 3 aspect
clear_fault  in  1  operator fault-clear request, level sampled
Lamp_M1  out  3  lane 0 lamp drive
Lamp_M2  out  3  lane 1 lamp drive
Lamp_M3  out  3  lane 2 lamp drive
Lamp_M4  out  3  lane 3 lamp drive
fault  out  1  latched fault flag
fault_code  out  3  0 none, 1 bad encoding, 2 conflict, 3 bad sequence, 4 short green, 5 short yellow
fault_lane  out  2  lane index (0..3 = M1..M4) of reported violation

Behaviour:
- Aspect encoding one-hot: 3'b100 red, 3'b010 yellow, 3'b001 green. Any other value (including 000) is illegal.
- Groups: A = lanes 0,1; B = lanes 2,3. Lanes within a group may be non-red together; conflict = any A lane and any B lane both non-red in the same sample.
- Legal per-lane transitions: hold, R->G, G->Y, Y->R. Illegal: G->R, R->Y, Y->G.
- Dwell counter per lane: number of consecutive samples at current aspect.
  - Set to 1 on aspect change; increments otherwise; saturates at 2^CNT_W-1.
  - Leaving G requires dwell >= MIN_GREEN (else code 4).
  - Leaving Y requires dwell >= MIN_YELLOW (else code 5).
- FSM states: PASS, FLASH_ON, FLASH_OFF.
- Reset (rst=0 at an edge): state PASS; all Lamp_M* = 3'b100; fault=0; fault_code=0; fault_lane=0; previous-aspect registers = red; dwell counters = 1; flash counter = 0. Reset mid-fault behaves identically.
- PASS, no violation: Lamp_M* <= Light_M* at each edge (1-cycle latency); previous-aspect and dwell registers update.
- PASS, violation sampled at edge k: at the same edge k:
  - fault <= 1 and fault_code/fault_lane are set.
  - All Lamp_M* <= 3'b100; state <= FLASH_ON; flash counter <= 0.
  - The offending aspect never appears on any Lamp_M*.
- Simultaneous violations: the lowest code number wins (1>2>3>4/5 priority; 4 and 5 cannot coincide on one lane). Within the winning code, the lowest lane index wins. For a conflict, fault_lane = lowest-indexed non-red lane.
- FLASH_ON: lamps all 3'b100. FLASH_OFF: lamps all 3'b000. Toggle after FLASH_HALF cycles in each state; counter resets on each toggle.
- In FLASH states:
  - No checks are run; fault_code and fault_lane are held.
  - clear_fault=1 with all four inputs 3'b100 at an edge -> next state PASS; fault=0; fault_code=0; fault_lane=0; lamps 3'b100; previous aspects red; dwell counters = 1.
  - clear_fault=1 with any input non-red is ignored.
- clear_fault in PASS has no effect.
- Fault remains latched indefinitely without a valid clear or reset.

Test Plan:
- Legal cycle (defaults): M1,M2 G for 5 cycles, Y for 2, R; then M3,M4 same pattern -> fault stays 0; each Lamp_M* equals its Light_M* delayed 1 cycle.
- Conflict: from all red, drive M1=001 and M3=001 in the same cycle -> after that edge fault=1, fault_code=2, fault_lane=0; all Lamp_M*=100; Lamp_M3 never shows 001.
- Short green: M2 R->G, held 2 cycles, then Y -> fault_code=4, fault_lane=1; held 3 cycles then Y -> no fault.
- Priority: same cycle M4=3'b011 and M1 G->R after a valid green -> fault_code=1, fault_lane=3.
- Flash/clear: in fault, lamps read 100 for 4 cycles, then 000 for 4 cycles, repeating. clear_fault=1 with M2=001 -> still fault. clear_fault=1 with all inputs 100 -> next cycle fault=0, code=0, lamps follow inputs; a subsequent R->G raises no fault.
- Reset mid-flash: rst=0 for one edge during FLASH_OFF -> fault=0, fault_code=0, fault_lane=0, all lamps 100, state PASS.
